// File: rtl/data_memory_responder.sv
// Word-addressed data memory slave with a fixed wait-state count and a one-cycle mem_ready pulse.
// Optional macro MEM_ALIGN_CHECK_EN rejects misaligned or out-of-range byte addresses.
module data_memory_responder #(
  parameter int DEPTH_WORDS = 32,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] data_address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        mem_ready,
  output logic        mem_error
);

  localparam int          IDX_W         = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_CNT_INIT = WAIT_STATES[3:0];

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t           state, next_state;
  logic [3:0]       wait_cnt;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      wdata_q;
  logic             rd_q, wr_q, err_q;
  logic             req, addr_err, resp_active;

  logic [31:0] mem [DEPTH_WORDS] = '{0: 32'h0000_0005, 1: 32'h0000_0003,
                                     2: 32'h0000_000C, default: 32'h0};

  assign req = mem_read | mem_write;

`ifdef MEM_ALIGN_CHECK_EN
  assign addr_err = (data_address[1:0] != 2'b00) || (data_address[31:IDX_W+2] != '0);
`else
  logic unused_addr_bits;
  assign addr_err         = 1'b0;
  assign unused_addr_bits = ^{data_address[31:IDX_W+2], data_address[1:0]};
`endif

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (req) next_state = (WAIT_STATES == 0) ? RESP : BUSY;
      BUSY:    if (wait_cnt <= 4'd1) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
      idx_q    <= '0;
      wdata_q  <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state <= next_state;
      if (state == IDLE && req) begin
        wait_cnt <= WAIT_CNT_INIT;
        idx_q    <= data_address[IDX_W+1:2];
        wdata_q  <= write_data;
        rd_q     <= mem_read;
        wr_q     <= mem_write;
        err_q    <= (mem_read & mem_write) | addr_err;
      end else if (state == BUSY) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
    end
  end

  // NOTE: the storage array has no reset; contents survive reset and only the commit below changes them.
  always_ff @(posedge clk) begin
    if (reset && state == RESP && wr_q && !err_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

  // Gating with reset keeps an access aborted in RESP from showing a completion pulse.
  assign resp_active = (state == RESP) && reset;
  assign mem_ready   = resp_active;
  assign mem_error   = resp_active && err_q;
  assign read_data   = (resp_active && rd_q && !err_q) ? mem[idx_q] : 32'h0;

endmodule
